serial_subtractor: RTL and testbench

Bit-serial subtractor: computes `a - b` over WIDTH clock cycles, LSB first, using one full-subtractor cell (two half-subtractor stages plus OR) and a registered borrow. Sits in the arithmetic datapath as the sequential consumer of the half-subtractor cell's `diff`/`borrow` outputs. It trades throughput for area where the parallel ripple subtractor is too large. A start/busy/done handshake connects it to a controller.

---
 rtl/serial_subtractor.sv | 133 +++++++++++++
 tb/tb_serial_subtractor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b over WIDTH cycles, LSB first, with a start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf_o is tied low.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o
);
    // state   | meaning
    // S_IDLE  | waiting for start; last result held
    // S_SHIFT | one difference bit per cycle, LSB first
    // S_DONE  | result valid for one cycle; start re-accepts
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             d_bit;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    assign d_bit = a_q[0] ^ b_q[0] ^ bin_q;
    assign bout  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);

    // The minuend register doubles as the result shifter: difference bits
    // enter at the MSB as the consumed operand bits leave at the LSB.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    state_d = S_SHIFT;
                    a_d     = a_i;
                    b_d     = b_i;
                    cnt_d   = '0;
                    bin_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_i[WIDTH-1];
`endif
                end
            end
            S_SHIFT: begin
                a_d   = {d_bit, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                bin_d = bout;
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    diff_d   = {d_bit, a_q[WIDTH-1:1]};
                    borrow_d = bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy_o   = (state_q == S_SHIFT);
    assign done_o   = (state_q == S_DONE);
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf_o    = ovf_q;
`else
    assign ovf_o    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); honours SERIAL_SUB_OVF_EN for the ovf expectation.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] diff_o;
    logic         borrow_o;
    logic         ovf_o;

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] sb_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .diff_o  (diff_o),
        .borrow_o(borrow_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ovf, borrow, diff}
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] full;
        logic       ovf;
        full = {1'b0, a} - {1'b0, b};
`ifdef SERIAL_SUB_OVF_EN
        ovf = (a[7] ^ b[7]) & (a[7] ^ full[7]);
`else
        ovf = 1'b0;
`endif
        return {ovf, full[8], full[7:0]};
    endfunction

    always @(negedge clk_i) begin
        logic [9:0] e;
        if (!rst_i) begin
            chk("busy_done_excl", {31'b0, busy_o & done_o}, 32'h0);
            if (done_o) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_done", {31'b0, done_o}, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk("diff",   {24'b0, diff_o},   {24'b0, e[7:0]});
                    chk("borrow", {31'b0, borrow_o}, {31'b0, e[8]});
                    chk("ovf",    {31'b0, ovf_o},    {31'b0, e[9]});
                end
            end
        end
    end

    // Called just after a negedge; returns right after the accepting posedge.
    task automatic do_accept(input logic [7:0] a, input logic [7:0] b);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        sb_q.push_back(model(a, b));
        @(posedge clk_i);
    endtask

    // Checks busy for W cycles then the done cycle. inject_at>0 pulses a
    // junk start in that busy cycle; hold keeps start high with junk operands.
    task automatic check_frame(input string tag, input int inject_at, input bit hold);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk_i);
            if (i == 1) begin
                if (hold) begin
                    a_i = 8'hFF;
                    b_i = 8'hFF;
                end else begin
                    start_i = 1'b0;
                end
            end
            if (i == inject_at) begin
                start_i = 1'b1;
                a_i     = 8'hFF;
                b_i     = 8'hFF;
            end else if (!hold && i == inject_at + 1) begin
                start_i = 1'b0;
            end
            chk({tag, "_busy"}, {31'b0, busy_o}, 32'h1);
            chk({tag, "_nodone"}, {31'b0, done_o}, 32'h0);
        end
        @(negedge clk_i);
        chk({tag, "_done"}, {31'b0, done_o}, 32'h1);
        chk({tag, "_notbusy"}, {31'b0, busy_o}, 32'h0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"},   {31'b0, busy_o},   32'h0);
        chk({tag, "_done"},   {31'b0, done_o},   32'h0);
        chk({tag, "_diff"},   {24'b0, diff_o},   32'h0);
        chk({tag, "_borrow"}, {31'b0, borrow_o}, 32'h0);
        chk({tag, "_ovf"},    {31'b0, ovf_o},    32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst_i   = 1'b1;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        #1;
        check_zero_outputs("reset");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Basic case with full timing check and one-cycle done
        @(negedge clk_i);
        do_accept(8'h5A, 8'h3C);
        check_frame("t1", 0, 1'b0);
        @(negedge clk_i);
        chk("t1_done_one_cycle", {31'b0, done_o}, 32'h0);

        do_accept(8'h00, 8'h01);
        check_frame("t2", 0, 1'b0);

        @(negedge clk_i);
        do_accept(8'h80, 8'h01);
        check_frame("t3", 0, 1'b0);

        // Start during SHIFT must be ignored
        @(negedge clk_i);
        do_accept(8'h10, 8'h05);
        check_frame("t4", 3, 1'b0);
        @(negedge clk_i);
        chk("t4_idle_after", {31'b0, busy_o | done_o}, 32'h0);

        // Back-to-back with start held high
        do_accept(8'h03, 8'h02);
        check_frame("t5a", 0, 1'b1);
        do_accept(8'h02, 8'h03);
        check_frame("t5b", 0, 1'b0);

        // A few random operands
        for (int n = 0; n < 6; n++) begin
            @(negedge clk_i);
            do_accept(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            check_frame("rnd", 0, 1'b0);
        end

        // Async reset in the middle of an operation
        @(negedge clk_i);
        do_accept(8'h7F, 8'h80);
        repeat (4) @(negedge clk_i);
        start_i = 1'b0;
        #2;
        rst_i = 1'b1;
        void'(sb_q.pop_back());
        #1;
        check_zero_outputs("midrst");
        @(negedge clk_i);
        rst_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        chk("midrst_no_done", dones, 0);

        do_accept(8'hC8, 8'h64);
        check_frame("post_rst", 0, 1'b0);

        repeat (3) @(negedge clk_i);
        chk("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
